// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
// - ctrl_t: decoder control bundle carried from decode into execute. Its
//   all-zero value is the bubble: no register write, no memory write, no
//   branch, no jump.
// - RES_*: result_src encodings (ALU, memory load, PC+4).
// - FWD_*: ALU operand forwarding selects (register file, writeback, memory).
package pipeline_pkg;

    typedef struct packed {
        logic [1:0] result_src;
        logic       mem_write;
        logic [3:0] alu_control;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic       branch;
        logic       pc_alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational hazard unit for the decode/execute boundary.
// Inputs : execute-stage load information (result_src_e, valid_e, rd_e),
//          decode sources (rs1_d, rs2_d), execute sources (rs1_e, rs2_e),
//          later-stage destinations and write enables (rd_m/w, reg_write_m/w).
// Outputs: lw_stall (load-use hazard), forward_a_e / forward_b_e.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [1:0]        result_src_e,
    input  logic              valid_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic              lw_stall,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e
);

    logic [REG_AW-1:0] rs_e [2];
    logic [1:0]        fwd  [2];

    assign rs_e[0] = rs1_e;
    assign rs_e[1] = rs2_e;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    // The memory stage holds the younger result and therefore wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] =
                (reg_write_m && (rd_m != '0) && (rd_m == rs_e[gi])) ? FWD_MEM :
                (reg_write_w && (rd_w != '0) && (rd_w == rs_e[gi])) ? FWD_WB  :
                                                                      FWD_RF;
        end
    endgenerate

    assign forward_a_e = fwd[0];
    assign forward_b_e = fwd[1];

    // A load's data is not available until the end of the memory stage, so a
    // dependent instruction directly behind it must wait one cycle.
    assign lw_stall = (result_src_e == RES_MEM) && valid_e && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with hazard handling.
// Inputs : decoder controls and operands (*_d), source/dest indices,
//          redirect pc_src_e, memory/writeback destinations and enables.
// Outputs: registered copies (*_e) plus valid_e, stall_f/stall_d, flush_d,
//          forward_a_e/forward_b_e for the ALU input muxes.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        result_src_d,
    input  logic              mem_write_d,
    input  logic              reg_write_d,
    input  logic              alu_src_d,
    input  logic              jump_d,
    input  logic              branch_d,
    input  logic              pc_alu_src_d,
    input  logic [3:0]        alu_control_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc_plus4_d,
    input  logic [XLEN-1:0]   imm_ext_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              pc_src_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        result_src_e,
    output logic              mem_write_e,
    output logic              reg_write_e,
    output logic              alu_src_e,
    output logic              jump_e,
    output logic              branch_e,
    output logic              pc_alu_src_e,
    output logic [3:0]        alu_control_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [XLEN-1:0]   imm_ext_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,
    output logic              valid_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e
);

    ctrl_t             ctrl_d;
    ctrl_t             ctrl_reg;
    logic [XLEN-1:0]   rd1_reg, rd2_reg, pc_reg, pc_plus4_reg, imm_ext_reg;
    logic [REG_AW-1:0] rs1_reg, rs2_reg, rd_reg;
    logic              valid_reg;

    logic              lw_stall_raw;
    logic              lw_stall;
    logic [1:0]        fwd_a_raw, fwd_b_raw;
    logic              bubble;

    assign ctrl_d = '{
        result_src:  result_src_d,
        mem_write:   mem_write_d,
        alu_control: alu_control_d,
        alu_src:     alu_src_d,
        reg_write:   reg_write_d,
        jump:        jump_d,
        branch:      branch_d,
        pc_alu_src:  pc_alu_src_d
    };

    hazard_detect #(
        .REG_AW(REG_AW)
    ) u_hazard (
        .result_src_e(ctrl_reg.result_src),
        .valid_e     (valid_reg),
        .rd_e        (rd_reg),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_reg),
        .rs2_e       (rs2_reg),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .lw_stall    (lw_stall_raw),
        .forward_a_e (fwd_a_raw),
        .forward_b_e (fwd_b_raw)
    );

    // While in reset the execute register may not yet hold a defined value,
    // so the hazard outputs are forced quiet until reset is released.
    assign lw_stall    = lw_stall_raw && rst_n;
    assign stall_f     = lw_stall;
    assign stall_d     = lw_stall;
    assign flush_d     = pc_src_e;
    assign forward_a_e = rst_n ? fwd_a_raw : FWD_RF;
    assign forward_b_e = rst_n ? fwd_b_raw : FWD_RF;

    // Reset, redirect and load-use all produce the same all-zero bubble, so
    // their priority order collapses into a single clear condition.
    assign bubble = !rst_n || pc_src_e || lw_stall;

    always_ff @(posedge clk) begin
        if (bubble) begin
            ctrl_reg     <= CTRL_BUBBLE;
            rd1_reg      <= '0;
            rd2_reg      <= '0;
            pc_reg       <= '0;
            pc_plus4_reg <= '0;
            imm_ext_reg  <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            valid_reg    <= 1'b0;
        end else begin
            ctrl_reg     <= ctrl_d;
            rd1_reg      <= rd1_d;
            rd2_reg      <= rd2_d;
            pc_reg       <= pc_d;
            pc_plus4_reg <= pc_plus4_d;
            imm_ext_reg  <= imm_ext_d;
            rs1_reg      <= rs1_d;
            rs2_reg      <= rs2_d;
            rd_reg       <= rd_d;
            valid_reg    <= 1'b1;
        end
    end

    assign result_src_e  = ctrl_reg.result_src;
    assign mem_write_e   = ctrl_reg.mem_write;
    assign reg_write_e   = ctrl_reg.reg_write;
    assign alu_src_e     = ctrl_reg.alu_src;
    assign jump_e        = ctrl_reg.jump;
    assign branch_e      = ctrl_reg.branch;
    assign pc_alu_src_e  = ctrl_reg.pc_alu_src;
    assign alu_control_e = ctrl_reg.alu_control;
    assign rd1_e         = rd1_reg;
    assign rd2_e         = rd2_reg;
    assign pc_e          = pc_reg;
    assign pc_plus4_e    = pc_plus4_reg;
    assign imm_ext_e     = imm_ext_reg;
    assign rs1_e         = rs1_reg;
    assign rs2_e         = rs2_reg;
    assign rd_e          = rd_reg;
    assign valid_e       = valid_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver applies one decode-stage
// instruction per cycle, a reference model of the execute slot predicts the
// hazard outputs and next execute contents, and a monitor compares them.
module tb_id_ex_stage;

    typedef struct {
        logic [1:0]  result_src;
        logic        mem_write;
        logic        reg_write;
        logic        alu_src;
        logic        jump;
        logic        branch;
        logic        pc_alu_src;
        logic [3:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        valid;
    } instr_t;

    typedef struct {
        logic       stall;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
        instr_t     ex;
    } exp_t;

    logic clk;
    logic rst_n;
    logic pc_src_e;
    logic [4:0] rd_m, rd_w;
    logic reg_write_m, reg_write_w;
    instr_t dec;

    logic [1:0]  result_src_e;
    logic        mem_write_e, reg_write_e, alu_src_e, jump_e, branch_e, pc_alu_src_e;
    logic [3:0]  alu_control_e;
    logic [31:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        valid_e, stall_f, stall_d, flush_d;
    logic [1:0]  forward_a_e, forward_b_e;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    exp_t   sb_q[$];
    exp_t   mon_e;
    logic   mon_busy = 1'b0;
    instr_t slot;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .result_src_d(dec.result_src), .mem_write_d(dec.mem_write),
        .reg_write_d(dec.reg_write), .alu_src_d(dec.alu_src),
        .jump_d(dec.jump), .branch_d(dec.branch), .pc_alu_src_d(dec.pc_alu_src),
        .alu_control_d(dec.alu_control),
        .rd1_d(dec.rd1), .rd2_d(dec.rd2), .pc_d(dec.pc), .pc_plus4_d(dec.pc4),
        .imm_ext_d(dec.imm), .rs1_d(dec.rs1), .rs2_d(dec.rs2), .rd_d(dec.rd),
        .pc_src_e(pc_src_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_e(result_src_e), .mem_write_e(mem_write_e),
        .reg_write_e(reg_write_e), .alu_src_e(alu_src_e), .jump_e(jump_e),
        .branch_e(branch_e), .pc_alu_src_e(pc_alu_src_e),
        .alu_control_e(alu_control_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .imm_ext_e(imm_ext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .valid_e(valid_e), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t empty_instr();
        instr_t i;
        i.result_src = 2'd0; i.mem_write = 1'b0; i.reg_write = 1'b0;
        i.alu_src = 1'b0; i.jump = 1'b0; i.branch = 1'b0; i.pc_alu_src = 1'b0;
        i.alu_control = 4'd0; i.rd1 = 32'd0; i.rd2 = 32'd0; i.pc = 32'd0;
        i.pc4 = 32'd0; i.imm = 32'd0; i.rs1 = 5'd0; i.rs2 = 5'd0; i.rd = 5'd0;
        i.valid = 1'b0;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.result_src  = 2'($urandom_range(0, 2));
        i.mem_write   = 1'($urandom);
        i.reg_write   = 1'($urandom);
        i.alu_src     = 1'($urandom);
        i.jump        = 1'($urandom);
        i.branch      = 1'($urandom);
        i.pc_alu_src  = 1'($urandom);
        i.alu_control = 4'($urandom);
        i.rd1 = $urandom; i.rd2 = $urandom; i.pc = $urandom;
        i.pc4 = i.pc + 32'd4; i.imm = $urandom;
        i.rs1 = 5'($urandom_range(0, 7));
        i.rs2 = 5'($urandom_range(0, 7));
        i.rd  = 5'($urandom_range(0, 7));
        i.valid = 1'b0;
        return i;
    endfunction

    // The instruction in execute is a load whose (non-x0) result is read by
    // the instruction now in decode.
    function automatic logic needs_load_wait(instr_t ex, instr_t d);
        if (!ex.valid || ex.result_src != 2'd1 || ex.rd == 5'd0) return 1'b0;
        return (ex.rd == d.rs1) || (ex.rd == d.rs2);
    endfunction

    // Where the freshest value of register rs lives: the memory stage is the
    // youngest producer, then writeback, otherwise the register file.
    function automatic logic [1:0] fwd_model(logic [4:0] rs, logic [4:0] rdm,
                                              logic wm, logic [4:0] rdw, logic ww);
        if (rs == 5'd0)              return 2'b00;
        if (wm && rdm == rs)         return 2'b10;
        if (ww && rdw == rs)         return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (txn %0d)", name, act, exp, txn);
        end
    endtask

    // Apply one decode-stage cycle and record what the model predicts.
    task automatic step(input instr_t d, input logic rst, input logic psrc,
                        input logic [4:0] rdm, input logic wm,
                        input logic [4:0] rdw, input logic ww, output logic stalled);
        exp_t e;
        @(negedge clk);
        dec = d; rst_n = rst; pc_src_e = psrc;
        rd_m = rdm; reg_write_m = wm; rd_w = rdw; reg_write_w = ww;
        e.flush = psrc;
        e.stall = rst && needs_load_wait(slot, d);
        e.fa    = rst ? fwd_model(slot.rs1, rdm, wm, rdw, ww) : 2'b00;
        e.fb    = rst ? fwd_model(slot.rs2, rdm, wm, rdw, ww) : 2'b00;
        if (!rst || psrc || e.stall) begin
            slot = empty_instr();
        end else begin
            slot = d;
            slot.valid = 1'b1;
        end
        e.ex = slot;
        sb_q.push_back(e);
        stalled = e.stall;
    endtask

    // Monitor: hazard outputs are sampled mid-cycle, the execute register
    // just after the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                mon_busy = 1'b1;
                mon_e = sb_q.pop_front();
                check("stall_f", 32'(stall_f), 32'(mon_e.stall));
                check("stall_d", 32'(stall_d), 32'(mon_e.stall));
                check("flush_d", 32'(flush_d), 32'(mon_e.flush));
                check("forward_a_e", 32'(forward_a_e), 32'(mon_e.fa));
                check("forward_b_e", 32'(forward_b_e), 32'(mon_e.fb));
                @(posedge clk);
                #1;
                check("valid_e", 32'(valid_e), 32'(mon_e.ex.valid));
                check("result_src_e", 32'(result_src_e), 32'(mon_e.ex.result_src));
                check("mem_write_e", 32'(mem_write_e), 32'(mon_e.ex.mem_write));
                check("reg_write_e", 32'(reg_write_e), 32'(mon_e.ex.reg_write));
                check("alu_src_e", 32'(alu_src_e), 32'(mon_e.ex.alu_src));
                check("jump_e", 32'(jump_e), 32'(mon_e.ex.jump));
                check("branch_e", 32'(branch_e), 32'(mon_e.ex.branch));
                check("pc_alu_src_e", 32'(pc_alu_src_e), 32'(mon_e.ex.pc_alu_src));
                check("alu_control_e", 32'(alu_control_e), 32'(mon_e.ex.alu_control));
                check("rd1_e", rd1_e, mon_e.ex.rd1);
                check("rd2_e", rd2_e, mon_e.ex.rd2);
                check("pc_e", pc_e, mon_e.ex.pc);
                check("pc_plus4_e", pc_plus4_e, mon_e.ex.pc4);
                check("imm_ext_e", imm_ext_e, mon_e.ex.imm);
                check("rs1_e", 32'(rs1_e), 32'(mon_e.ex.rs1));
                check("rs2_e", 32'(rs2_e), 32'(mon_e.ex.rs2));
                check("rd_e", 32'(rd_e), 32'(mon_e.ex.rd));
                $display("txn %0d: valid_e=%0b rd_e=%0d stall=%0b flush=%0b fwd=%0d/%0d",
                         txn, valid_e, rd_e, stall_f, flush_d, forward_a_e, forward_b_e);
                txn++;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        instr_t d;
        logic   st;
        logic   rst_v, psrc_v;
        rst_n = 1'b0; pc_src_e = 1'b0;
        rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        dec  = rand_instr();
        slot = empty_instr();

        // Reset held with random decode inputs.
        repeat (2) step(rand_instr(), 1'b0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, st);

        // add x3, x1, x2
        d = empty_instr(); d.rs1 = 5'd1; d.rs2 = 5'd2; d.rd = 5'd3; d.reg_write = 1'b1;
        step(d, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, st);

        // lw x5 followed by a dependent instruction, held in decode while stalled.
        d = rand_instr(); d.result_src = 2'd1; d.rd = 5'd5; d.reg_write = 1'b1;
        step(d, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, st);
        d = rand_instr(); d.result_src = 2'd0; d.rs1 = 5'd5; d.rs2 = 5'd1; d.rd = 5'd6;
        step(d, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, st);
        step(d, 1'b1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, st);

        // Load into x0 never stalls.
        d = rand_instr(); d.result_src = 2'd1; d.rd = 5'd0;
        step(d, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, st);
        d = rand_instr(); d.result_src = 2'd0; d.rs1 = 5'd0; d.rs2 = 5'd0;
        step(d, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, st);

        // Redirect, then back-to-back redirects.
        d = rand_instr(); d.mem_write = 1'b1;
        step(d, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, st);
        step(rand_instr(), 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, st);
        d = rand_instr(); d.result_src = 2'd0;
        step(d, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, st);

        // Forward priority on rs1_e = 7.
        d = rand_instr(); d.result_src = 2'd0; d.rs1 = 5'd7;
        step(d, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, st);
        step(d, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, st);
        step(d, 1'b1, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, st);
        step(d, 1'b1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b1, st);

        // Random traffic; a stalled instruction is re-presented as the
        // IF/ID register would do.
        st = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!st) d = rand_instr();
            rst_v  = ($urandom_range(0, 39) != 0);
            psrc_v = ($urandom_range(0, 7) == 0);
            step(d, rst_v, psrc_v,
                 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), st);
            if (psrc_v || !rst_v) st = 1'b0;
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && (sb_q.size() != 0 || mon_busy); i++) @(posedge clk);
        #3;
        for (int i = 0; i < 5 && mon_busy; i++) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0 || mon_busy) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute boundary of the five-stage pipeline. Registers the decoder's control bundle and the decode-stage operands into the execute stage. Detects load-use hazards and inserts a one-cycle bubble, and flushes on a redirect from a taken branch or a jump. Produces the execute-stage operand forwarding selects consumed by the ALU input muxes.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register index width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  **synchronous, active-low reset**
- result_src_d  in  2  decoder result select: 0 ALU, 1 memory, 2 PC+4
- mem_write_d, reg_write_d, alu_src_d, jump_d, branch_d, pc_alu_src_d  in  1 each  decoder controls
- alu_control_d  in  4  decoder ALU operation
- rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d  in  XLEN each  decode-stage data
- rs1_d, rs2_d, rd_d  in  REG_AW each  register indices of the decode-stage instruction
- pc_src_e  in  1  execute-stage redirect (taken branch or jump)
- rd_m, rd_w  in  REG_AW  destinations in memory and writeback stages
- reg_write_m, reg_write_w  in  1  write enables in memory and writeback stages
- *_e outputs  out  same widths  registered copies of every *_d input above, plus rs1_e and rs2_e
- valid_e  out  1  execute stage holds a real instruction
- stall_f, stall_d  out  1  hold the PC and the IF/ID register
- flush_d  out  1  clear the IF/ID register
- forward_a_e, forward_b_e  out  2  ALU source select: 00 register file, 01 writeback, 10 memory stage

## Operation
- Load-use hazard: lw_stall = (result_src_e == 1) && valid_e && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d).
- stall_f = stall_d = lw_stall.
- flush_d = pc_src_e.
- Execute register update priority at each rising edge:
  - !rst_n: clear the register.
  - pc_src_e: insert a bubble.
  - lw_stall: insert a bubble.
  - Otherwise: capture all *_d inputs and set valid_e = 1.
- Bubble: every control output, data output and index output is 0, and valid_e = 0. A bubble has reg_write_e = mem_write_e = branch_e = jump_e = 0, so it has no architectural effect.
- pc_alu_src_d is captured as given. It is only meaningful when jump_d = 1.
- lw_stall and pc_src_e are mutually exclusive by construction, because a load in execute cannot redirect. If both arrive anyway, the flush takes priority.
- Forwarding for each of rs1_e and rs2_e:
  - Select 10 if reg_write_m && rd_m != 0 && rd_m == rs_e.
  - Otherwise select 01 if reg_write_w && rd_w != 0 && rd_w == rs_e.
  - Otherwise select 00.
  - The memory stage wins when both stages match.
- Register x0 never triggers a stall or a forward.

## Timing
- Reset value of every registered output is 0, including valid_e. Forward selects read 00 while the stage is in reset.
- Decode-to-execute latency is 1 cycle.
- stall_f, stall_d, flush_d and forward_*_e are combinational from current-cycle inputs and state, with no added latency.
- Load-use sequence:
  - Cycle N: lw in execute, dependent instruction in decode, so stall_* = 1.
  - Edge N→N+1: bubble enters execute; the dependent instruction is held in decode by stall_d.
  - Cycle N+1: stall_* = 0.
  - Edge N+1→N+2: the dependent instruction enters execute. forward = 01 when the load has reached writeback.
- Redirect: a cycle with pc_src_e = 1 makes both the IF/ID register and the execute register hold bubbles in the next cycle. This is a two-instruction penalty.
- Back-to-back redirects: each one clears the stage again, with no accumulation.
- Reset deasserted mid-stream: the first capture happens on the first edge with rst_n = 1.

## Structure
- Shared package pipeline_pkg holds:
  - ctrl_t packed struct: result_src, mem_write, alu_control, alu_src, reg_write, jump, branch, pc_alu_src. Its all-zero value is the bubble.
  - Constants RES_ALU, RES_MEM, RES_PC4.
  - Constants FWD_RF, FWD_WB, FWD_MEM.
- One sub-module, hazard_detect, is combinational and produces lw_stall and both forward selects. The top level holds only the execute register and the priority logic.

## Test plan
1. Reset: hold rst_n = 0 for 2 cycles with random *_d inputs -> all *_e outputs 0, valid_e 0, stall_f 0.
2. Pass-through: present add x3,x1,x2 with alu_control 0000, reg_write 1 -> next cycle rd_e = 3, alu_control_e = 0000, reg_write_e = 1, valid_e = 1.
3. Load-use: lw x5 in execute (rd_e = 5, result_src_e = 1), decode has rs1_d = 5 -> stall_f = stall_d = 1 for exactly 1 cycle, a bubble reaches execute, and the dependent instruction reaches execute one cycle later.
4. Load into x0: rd_e = 0, rs1_d = 0 -> stall_f stays 0.
5. Redirect: pc_src_e = 1 for one cycle -> flush_d = 1 that cycle, next-cycle valid_e = 0, mem_write_e = 0.
6. Forward priority: rs1_e = 7, rd_m = rd_w = 7, both write enables 1 -> forward_a_e = 10. With reg_write_m = 0 -> 01. With rd_w = 0 as well -> 00.
